// File: rtl/vip_stream_source_scheduler.sv
// Frame-boundary source scheduler: forwards whole packets from one of NUM_INPUTS Avalon-ST
// sources and only moves to a newly requested source once an image packet has completed.

module vip_sss_lane #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned SEL_WIDTH  = 2,
  parameter int unsigned LANE       = 0
) (
  input  logic [SEL_WIDTH-1:0]  cur_sel_i,
  input  logic                  grant_en_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  sop_i,
  input  logic                  eop_i,
  output logic                  ready_o,
  output logic                  acc_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  sop_o,
  output logic                  eop_o
);
  assign ready_o = grant_en_i & (cur_sel_i == SEL_WIDTH'(LANE));
  assign acc_o   = ready_o & valid_i;
  // Masked by acceptance so the top can simply OR all lanes together.
  assign data_o  = acc_o ? data_i : '0;
  assign sop_o   = acc_o & sop_i;
  assign eop_o   = acc_o & eop_i;
endmodule

module vip_stream_source_scheduler #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned SEL_WIDTH  = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_sop,
  input  logic [NUM_INPUTS-1:0]            in_eop,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic                             out_valid,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_sop,
  output logic                             out_eop,
  input  logic                             out_ready,
  input  logic [SEL_WIDTH-1:0]             sel_req,
  input  logic                             sel_update,
  output logic [SEL_WIDTH-1:0]             cur_sel,
  output logic                             switch_done,
  output logic                             err_pulse
);
  typedef enum logic {IDLE, PKT} state_e;

  localparam logic [SEL_WIDTH:0] NUM_SEL = (SEL_WIDTH+1)'(NUM_INPUTS);

  state_e                state_q, state_d;
  logic [SEL_WIDTH-1:0]  cur_sel_q, cur_sel_d, pend_sel_q, pend_sel_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  frame_bound_q, frame_bound_d;
  logic                  is_img_q, is_img_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic                  switch_done_q, switch_done_d;
  logic                  err_q, err_d;

  logic                                  adv, req_legal, switch_en, acc, acc_sop, acc_eop, acc_img;
  logic [SEL_WIDTH-1:0]                  sw_target;
  logic [NUM_INPUTS-1:0]                 lane_acc, lane_sop, lane_eop;
  logic [NUM_INPUTS-1:0][DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0]                 acc_data;

  assign adv       = ~out_valid_q | out_ready;
  assign req_legal = ({1'b0, sel_req} < NUM_SEL);
  assign switch_en = (state_q == IDLE) & frame_bound_q & pend_valid_q;
  // A request arriving on the apply cycle overrides the one already pending.
  assign sw_target = (sel_update & req_legal) ? sel_req : pend_sel_q;

  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
    vip_sss_lane #(
      .DATA_WIDTH(DATA_WIDTH), .SEL_WIDTH(SEL_WIDTH), .LANE(i)
    ) u_lane (
      .cur_sel_i (cur_sel_q),
      .grant_en_i(adv & ~switch_en),
      .valid_i   (in_valid[i]),
      .data_i    (in_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .sop_i     (in_sop[i]),
      .eop_i     (in_eop[i]),
      .ready_o   (in_ready[i]),
      .acc_o     (lane_acc[i]),
      .data_o    (lane_data[i]),
      .sop_o     (lane_sop[i]),
      .eop_o     (lane_eop[i])
    );
  end

  always_comb begin
    acc_data = '0;
    for (int i = 0; i < int'(NUM_INPUTS); i++) acc_data |= lane_data[i];
  end

  assign acc     = |lane_acc;
  assign acc_sop = |lane_sop;
  assign acc_eop = |lane_eop;
  assign acc_img = (acc_data[3:0] == 4'h0);

  always_comb begin
    state_d       = state_q;
    cur_sel_d     = cur_sel_q;
    pend_sel_d    = pend_sel_q;
    pend_valid_d  = pend_valid_q;
    frame_bound_d = frame_bound_q;
    is_img_d      = is_img_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    switch_done_d = 1'b0;
    err_d         = sel_update & ~req_legal;

    if (acc) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_data;
      out_sop_d   = acc_sop;
      out_eop_d   = acc_eop;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (switch_en) begin
      cur_sel_d     = sw_target;
      pend_valid_d  = 1'b0;
      frame_bound_d = 1'b1;
      switch_done_d = (sw_target != cur_sel_q);
    end else if (sel_update & req_legal) begin
      pend_sel_d   = sel_req;
      pend_valid_d = 1'b1;
    end

    // acc and switch_en are exclusive, so packet tracking never fights the switch.
    if (acc) begin
      if (acc_sop) begin
        is_img_d = acc_img;
        if (state_q == PKT) err_d = 1'b1;
        if (acc_eop) begin
          state_d       = IDLE;
          frame_bound_d = acc_img;
        end else begin
          state_d       = PKT;
          frame_bound_d = 1'b0;
        end
      end else if (acc_eop && state_q == PKT) begin
        state_d       = IDLE;
        frame_bound_d = is_img_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cur_sel_q     <= '0;
      pend_sel_q    <= '0;
      pend_valid_q  <= 1'b0;
      frame_bound_q <= 1'b1;
      is_img_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      switch_done_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_sel_q     <= cur_sel_d;
      pend_sel_q    <= pend_sel_d;
      pend_valid_q  <= pend_valid_d;
      frame_bound_q <= frame_bound_d;
      is_img_q      <= is_img_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      switch_done_q <= switch_done_d;
      err_q         <= err_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_sop     = out_sop_q;
  assign out_eop     = out_eop_q;
  assign cur_sel     = cur_sel_q;
  assign switch_done = switch_done_q;
  assign err_pulse   = err_q;
endmodule

// File: tb/tb_vip_stream_source_scheduler.sv
// Bench for vip_stream_source_scheduler: packet-level model with a one-entry output queue,
// checked every cycle, plus literal expectations per scenario.
module tb_vip_stream_source_scheduler;
  localparam int DW = 10;
  localparam int NI = 2;
  localparam int SW = 2;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NI-1:0]    in_valid = '0, in_sop = '0, in_eop = '0, in_ready;
  logic [NI*DW-1:0] in_data = '0;
  logic             out_valid, out_sop, out_eop;
  logic             out_ready = 1'b1;
  logic [DW-1:0]    out_data;
  logic [SW-1:0]    sel_req = '0, cur_sel;
  logic             sel_update = 1'b0, switch_done, err_pulse;

  always #5 clk = ~clk;

  vip_stream_source_scheduler #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_ready(out_ready), .sel_req(sel_req), .sel_update(sel_update),
    .cur_sel(cur_sel), .switch_done(switch_done), .err_pulse(err_pulse)
  );

  int n_chk = 0, n_fail = 0;
  int done_cnt = 0, err_cnt = 0;
  beat_t src_q[NI][$];
  logic [DW-1:0] xfer_log[$];

  // Model: selection/pending request, whether a packet is open, whether the last completed
  // packet was an image, and the beats sitting in the single output slot.
  logic [SW-1:0] m_sel = '0, m_pend_sel = '0;
  bit m_pend_v = 0, m_inpkt = 0, m_img = 0, m_bound = 1, m_done = 0, m_err = 0;
  beat_t m_outq[$];
  bit [NI-1:0] m_take = '0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void chk_log(string name, int idx, logic [DW-1:0] exp);
    if (idx >= xfer_log.size()) begin
      n_chk++; n_fail++;
      $display("FAIL %s: only %0d beats transferred, expected %0h at index %0d", name, xfer_log.size(), exp, idx);
    end else chk(name, xfer_log[idx], exp);
  endfunction

  always @(negedge clk) begin
    bit sw, can_take, acc, upd_ok;
    logic [SW-1:0] tgt;
    logic [NI-1:0] exp_rdy;
    beat_t b;
    m_take = '0;
    if (rst) begin
      m_sel = '0; m_pend_sel = '0; m_pend_v = 0; m_inpkt = 0; m_img = 0; m_bound = 1;
      m_done = 0; m_err = 0; m_outq.delete();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", {out_data, out_sop, out_eop}, 0);
      chk("rst_cur_sel", cur_sel, 0);
      chk("rst_switch_done", switch_done, 0);
      chk("rst_err_pulse", err_pulse, 0);
    end else begin
      upd_ok   = sel_update && (sel_req < NI);
      sw       = !m_inpkt && m_bound && m_pend_v;
      tgt      = upd_ok ? sel_req : m_pend_sel;
      can_take = (m_outq.size() == 0) || out_ready;
      exp_rdy  = '0;
      if (can_take && !sw) exp_rdy[m_sel] = 1'b1;

      chk("in_ready", in_ready, exp_rdy);
      chk("out_valid", out_valid, m_outq.size() != 0);
      if (m_outq.size() != 0) chk("out_beat", {out_data, out_sop, out_eop}, m_outq[0]);
      chk("cur_sel", cur_sel, m_sel);
      chk("switch_done", switch_done, m_done);
      chk("err_pulse", err_pulse, m_err);
      if (switch_done) done_cnt++;
      if (err_pulse) err_cnt++;
      if (out_valid && out_ready) xfer_log.push_back(out_data);

      acc    = exp_rdy[m_sel] && in_valid[m_sel];
      b.data = in_data[m_sel*DW +: DW];
      b.sop  = in_sop[m_sel];
      b.eop  = in_eop[m_sel];
      if (m_outq.size() != 0 && out_ready) void'(m_outq.pop_front());
      if (acc) begin
        m_outq.push_back(b);
        m_take[m_sel] = 1'b1;
      end

      m_done = 0;
      m_err  = sel_update && !upd_ok;
      if (sw) begin
        m_done = (tgt != m_sel);
        m_sel = tgt; m_pend_v = 0; m_bound = 1;
      end else if (upd_ok) begin
        m_pend_sel = sel_req; m_pend_v = 1;
      end
      if (acc) begin
        if (b.sop) begin
          if (m_inpkt) m_err = 1;
          m_img   = (b.data[3:0] == 4'h0);
          m_inpkt = !b.eop;
          m_bound = b.eop && m_img;
        end else if (b.eop && m_inpkt) begin
          m_inpkt = 0;
          m_bound = m_img;
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < NI; i++) begin
      in_valid[i] = src_q[i].size() != 0;
      if (src_q[i].size() != 0) begin
        in_data[i*DW +: DW] = src_q[i][0].data;
        in_sop[i] = src_q[i][0].sop;
        in_eop[i] = src_q[i][0].eop;
      end else begin
        in_data[i*DW +: DW] = '0;
        in_sop[i] = 1'b0;
        in_eop[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    sel_update = 1'b0;
    for (int i = 0; i < NI; i++)
      if (m_take[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    drive();
  endtask

  task automatic idle(int n);
    repeat (n) tick();
  endtask

  // Beat data: source in [9:8], beat index in [7:4], packet type in [3:0].
  task automatic load_pkt(int s, int t, int n, bit with_eop);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = DW'((s << 8) | (k << 4) | t);
      b.sop  = (k == 0);
      b.eop  = with_eop && (k == n - 1);
      src_q[s].push_back(b);
    end
    drive();
  endtask

  task automatic wait_left(int s, int n);
    int k = 0;
    while (src_q[s].size() > n && k < 200) begin tick(); k++; end
    if (src_q[s].size() > n) begin
      n_chk++; n_fail++;
      $display("FAIL wait_left src%0d: %0d beats still queued, expected %0d", s, src_q[s].size(), n);
    end
  endtask

  task automatic request(int s);
    sel_req = SW'(s);
    sel_update = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    rst = 1'b0;
    idle(2);

    // 1: steady state, ctrl + image from source 0
    xfer_log.delete();
    load_pkt(0, 4'hF, 3, 1);
    load_pkt(0, 4'h0, 8, 1);
    idle(12);
    chk("t1_beats", xfer_log.size(), 11);
    chk_log("t1_ctrl_sop", 0, 10'h00F);
    chk_log("t1_img_sop", 3, 10'h000);
    chk_log("t1_img_eop", 10, 10'h070);
    chk("t1_cur_sel", cur_sel, 0);

    // 2: request source 1 on beat 4 of a source-0 image
    xfer_log.delete(); done_cnt = 0;
    load_pkt(1, 4'h0, 4, 1);
    load_pkt(0, 4'h0, 8, 1);
    wait_left(0, 5);
    request(1);
    wait_left(0, 0);
    idle(8);
    chk("t2_done_cnt", done_cnt, 1);
    chk("t2_cur_sel", cur_sel, 1);
    chk("t2_beats", xfer_log.size(), 12);
    chk_log("t2_src0_eop", 7, 10'h070);
    chk_log("t2_src1_sop", 8, 10'h100);
    chk_log("t2_src1_eop", 11, 10'h130);

    // 3: control packets never open the boundary; the image eop does
    xfer_log.delete(); done_cnt = 0;
    load_pkt(1, 4'hF, 3, 1);
    load_pkt(1, 4'h5, 2, 1);
    load_pkt(1, 4'h0, 4, 1);
    load_pkt(0, 4'h0, 2, 1);
    wait_left(1, 8);
    request(0);
    wait_left(1, 4);
    chk("t3_cur_sel_after_ctrl", cur_sel, 1);
    chk("t3_no_done_after_ctrl", done_cnt, 0);
    wait_left(1, 0);
    idle(6);
    chk("t3_cur_sel", cur_sel, 0);
    chk("t3_done_cnt", done_cnt, 1);
    chk("t3_beats", xfer_log.size(), 11);
    chk_log("t3_src0_sop", 9, 10'h000);

    // 4: backpressure 1,0,0,1 mid-packet
    xfer_log.delete();
    load_pkt(0, 4'h0, 6, 1);
    wait_left(0, 4);
    foreach (xfer_log[k]) ;
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    out_ready = 1'b0; tick();
    out_ready = 1'b1; tick();
    wait_left(0, 0);
    idle(4);
    chk("t4_beats", xfer_log.size(), 6);
    for (int k = 0; k < 6; k++) chk_log("t4_beat", k, DW'(k << 4));

    // 5a: illegal source index
    err_cnt = 0;
    request(3);
    idle(3);
    chk("t5a_err_cnt", err_cnt, 1);
    chk("t5a_cur_sel", cur_sel, 0);

    // 5b: sop at beat 5 of an image restarts the packet
    xfer_log.delete(); err_cnt = 0; done_cnt = 0;
    load_pkt(0, 4'h0, 4, 0);
    load_pkt(0, 4'h0, 8, 1);
    wait_left(0, 0);
    idle(4);
    chk("t5b_err_cnt", err_cnt, 1);
    chk("t5b_cur_sel", cur_sel, 0);
    chk("t5b_no_switch", done_cnt, 0);
    chk("t5b_beats", xfer_log.size(), 12);
    chk_log("t5b_restart_sop", 4, 10'h000);
    chk_log("t5b_eop", 11, 10'h070);

    // 6: reset during beat 3 with a request pending
    done_cnt = 0;
    load_pkt(0, 4'h0, 8, 1);
    wait_left(0, 7);
    request(1);
    wait_left(0, 6);
    rst = 1'b1;
    #1;
    chk("t6_async_out_valid", out_valid, 0);
    idle(2);
    src_q[0].delete();
    xfer_log.delete();
    rst = 1'b0;
    load_pkt(0, 4'h0, 4, 1);
    idle(8);
    chk("t6_beats", xfer_log.size(), 4);
    chk_log("t6_sop", 0, 10'h000);
    chk_log("t6_eop", 3, 10'h030);
    chk("t6_cur_sel", cur_sel, 0);
    chk("t6_no_switch", done_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
